// File: rtl/jk_bank_pkg.sv
// Shared types and constants for the JK register bank.
// Mode encoding matches the 2-bit mode port of jk_register_bank.
package jk_bank_pkg;

    typedef enum logic [1:0] {
        MODE_JK    = 2'b00,
        MODE_T     = 2'b01,
        MODE_LOAD  = 2'b10,
        MODE_COUNT = 2'b11
    } jk_mode_t;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

endpackage

// File: rtl/jk_bit_cell.sv
// One JK flip-flop with async reset to a per-bit value, synchronous
// active-low clear/preset (clear wins) and an enable gating the JK function.
module jk_bit_cell (
    input  logic clk,
    input  logic rst,
    input  logic rst_val,
    input  logic preset_n,
    input  logic clear_n,
    input  logic en,
    input  logic j,
    input  logic k,
    output logic q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= rst_val;
        end else if (!clear_n) begin
            q <= 1'b0;
        end else if (!preset_n) begin
            q <= 1'b1;
        end else if (en) begin
            case ({j, k})
                2'b00:   q <= q;
                2'b01:   q <= 1'b0;
                2'b10:   q <= 1'b1;
                default: q <= ~q;
            endcase
        end
    end

endmodule

// File: rtl/jk_register_bank.sv
// Bank of WIDTH JK flip-flops with JK / toggle / load / up-down count modes.
// Define JK_BANK_WRAP_FLAG_EN to add the sticky wrap_flag output.
module jk_register_bank
    import jk_bank_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic [WIDTH-1:0] d,
    input  logic [WIDTH-1:0] preset_n,
    input  logic [WIDTH-1:0] clear_n,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc
`ifdef JK_BANK_WRAP_FLAG_EN
    ,
    output logic             wrap_flag
`endif
);

    jk_mode_t         mode_e;
    logic             dir;
    logic [WIDTH-1:0] carry;
    logic [WIDTH-1:0] cell_j;
    logic [WIDTH-1:0] cell_k;
    logic             at_terminal;

    assign mode_e = jk_mode_t'(mode);
    assign dir    = k[0];

    // Bit i toggles when every lower bit is 1 (up) or 0 (down); uses current q.
    always_comb begin
        carry    = '0;
        carry[0] = 1'b1;
        for (int i = 1; i < WIDTH; i++) begin
            carry[i] = carry[i-1] & (q[i-1] ^ dir);
        end
    end

    always_comb begin
        cell_j = j;
        cell_k = k;
        case (mode_e)
            MODE_JK: begin
                cell_j = j;
                cell_k = k;
            end
            MODE_T: begin
                cell_j = j;
                cell_k = j;
            end
            MODE_LOAD: begin
                cell_j = d;
                cell_k = ~d;
            end
            MODE_COUNT: begin
                cell_j = carry;
                cell_k = carry;
            end
            default: begin
                cell_j = j;
                cell_k = k;
            end
        endcase
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        jk_bit_cell u_cell (
            .clk      (clk),
            .rst      (rst),
            .rst_val  (RESET_VALUE[i]),
            .preset_n (preset_n[i]),
            .clear_n  (clear_n[i]),
            .en       (en),
            .j        (cell_j[i]),
            .k        (cell_k[i]),
            .q        (q[i])
        );
    end

    assign qbar        = ~q;
    assign at_terminal = (dir == DIR_UP) ? (&q) : (~|q);
    assign tc          = en & (mode_e == MODE_COUNT) & at_terminal;

`ifdef JK_BANK_WRAP_FLAG_EN
    // tc is never high in MODE_LOAD, so set and clear cannot collide.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrap_flag <= 1'b0;
        end else if (tc) begin
            wrap_flag <= 1'b1;
        end else if (en && (mode_e == MODE_LOAD)) begin
            wrap_flag <= 1'b0;
        end
    end
`endif

endmodule
